// File: rtl/bus_launch_pkg.sv
// Shared types and defaults for the bus synchronizer source-side launcher.
package bus_launch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } launch_state_t;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_GAP_CYCLES  = 8;

    // Counter holds at most max(hold,gap)-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bus_launch_if.sv
// Valid/ready word input plus the launched bus/level toward the destination domain.
interface bus_launch_if
    import bus_launch_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] unsync_bus;
    logic             bus_en;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, unsync_bus, bus_en, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, unsync_bus, bus_en, busy
    );
endinterface

// File: rtl/bus_launch_skid.sv
// One-entry valid/ready holding register; accepts only while empty.
module bus_launch_skid
    import bus_launch_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && !valid_q) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/bus_launch_ctrl.sv
// Source-domain launcher: holds unsync_bus stable while bus_en is high and through the gap.
// Optional one-word skid buffer enabled by defining BUS_LAUNCH_SKID_EN.
module bus_launch_ctrl
    import bus_launch_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    bus_launch_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_chk
        $error("bus_launch_ctrl: HOLD_CYCLES and GAP_CYCLES must both be >= 1");
    end

    launch_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_en_q, bus_en_d;
    logic [WIDTH-1:0] unsync_bus_q, unsync_bus_d;
    logic             launch;
    logic [WIDTH-1:0] launch_data;

`ifdef BUS_LAUNCH_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_pop;
    logic             skid_ready;

    // Words arriving in IDLE with the skid empty bypass it and launch directly.
    bus_launch_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.in_data),
        .in_valid  (bus.in_valid && (state_q != IDLE)),
        .in_ready  (skid_ready),
        .out_data  (skid_data),
        .out_valid (skid_valid),
        .out_ready (skid_pop)
    );

    assign bus.in_ready = skid_ready;
`else
    assign bus.in_ready = (state_q == IDLE);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_en_d     = bus_en_q;
        unsync_bus_d = unsync_bus_q;
        launch       = 1'b0;
        launch_data  = bus.in_data;
`ifdef BUS_LAUNCH_SKID_EN
        skid_pop     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BUS_LAUNCH_SKID_EN
                if (skid_valid) begin
                    launch      = 1'b1;
                    launch_data = skid_data;
                    skid_pop    = 1'b1;
                end else if (bus.in_valid) begin
                    launch = 1'b1;
                end
`else
                if (bus.in_valid) begin
                    launch = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    bus_en_d = 1'b0;
                    cnt_d    = CNT_W'(GAP_CYCLES - 1);
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
`ifdef BUS_LAUNCH_SKID_EN
                    if (skid_valid) begin
                        launch      = 1'b1;
                        launch_data = skid_data;
                        skid_pop    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            unsync_bus_d = launch_data;
            bus_en_d     = 1'b1;
            cnt_d        = CNT_W'(HOLD_CYCLES - 1);
            state_d      = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_en_q     <= 1'b0;
            unsync_bus_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_en_q     <= bus_en_d;
            unsync_bus_q <= unsync_bus_d;
        end
    end

    assign bus.unsync_bus = unsync_bus_q;
    assign bus.bus_en     = bus_en_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
